// File: rtl/hangman_engine.sv
// Hangman game engine: latches an N-letter word on new_game and evaluates
// one guess per guess_strobe rising edge.
//   in : clk, resetn (async, active-high), new_game, word_flat,
//        guess, guess_strobe
//   out: display_flat, revealed, wrong_count, hit/miss/repeat_guess
//        pulses, game_status (0 PLAY, 1 LOSE, 2 WIN, 3 IDLE)
module hangman_engine #(
  parameter int          WORD_LEN  = 4,
  parameter int          LW        = 6,
  parameter int          MAX_WRONG = 4,
  parameter int          WCW       = 3,
  parameter logic [LW-1:0] DASH    = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   new_game,
  input  logic [WORD_LEN*LW-1:0] word_flat,
  input  logic [LW-1:0]          guess,
  input  logic                   guess_strobe,
  output logic [WORD_LEN*LW-1:0] display_flat,
  output logic [WORD_LEN-1:0]    revealed,
  output logic [WCW-1:0]         wrong_count,
  output logic                   hit,
  output logic                   miss,
  output logic                   repeat_guess,
  output logic [1:0]             game_status
);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_EVAL, S_WIN, S_LOSE
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD_LEN*LW-1:0]  word_q, word_d;
  logic [WORD_LEN-1:0]     rev_q, rev_d;
  logic [WCW-1:0]          wrong_q, wrong_d;
  logic [LW-1:0]           hist_q [MAX_WRONG];
  logic [LW-1:0]           hist_d [MAX_WRONG];
  logic [LW-1:0]           guess_q, guess_d;
  logic                    strobe_q;
  logic                    hit_q, hit_d;
  logic                    miss_q, miss_d;
  logic                    rep_q, rep_d;

  logic                    strobe_edge;
  logic [WORD_LEN-1:0]     match;
  logic [WORD_LEN-1:0]     fresh;
  logic [WORD_LEN-1:0]     stale;
  logic                    hist_rep;

  assign strobe_edge = guess_strobe & ~strobe_q;

  always_comb begin
    match    = '0;
    hist_rep = 1'b0;
    for (int i = 0; i < WORD_LEN; i++)
      match[i] = (word_q[i*LW +: LW] == guess_q);
    // only slots below wrong_count hold real misses
    for (int k = 0; k < MAX_WRONG; k++)
      if (WCW'(k) < wrong_q && hist_q[k] == guess_q)
        hist_rep = 1'b1;
    fresh = match & ~rev_q;
    stale = match & rev_q;
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    rev_d   = rev_q;
    wrong_d = wrong_q;
    hist_d  = hist_q;
    guess_d = guess_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    rep_d   = 1'b0;
    if (new_game) begin
      word_d  = word_flat;
      rev_d   = '0;
      wrong_d = '0;
      for (int k = 0; k < MAX_WRONG; k++)
        hist_d[k] = '0;
      state_d = S_PLAY;
    end else begin
      unique case (state_q)
        S_PLAY: begin
          if (strobe_edge) begin
            guess_d = guess;
            state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          state_d = S_PLAY;
          if (guess_q == DASH || hist_rep ||
              (|stale && ~|fresh)) begin
            rep_d = 1'b1;
          end else if (|fresh) begin
            rev_d = rev_q | match;
            hit_d = 1'b1;
            if (&rev_d)
              state_d = S_WIN;
          end else begin
            miss_d = 1'b1;
            for (int k = 0; k < MAX_WRONG; k++)
              if (WCW'(k) == wrong_q)
                hist_d[k] = guess_q;
            if (wrong_q < WCW'(MAX_WRONG))
              wrong_d = wrong_q + 1'b1;
            if (wrong_d == WCW'(MAX_WRONG))
              state_d = S_LOSE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      rev_q    <= '0;
      wrong_q  <= '0;
      guess_q  <= '0;
      strobe_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      rep_q    <= 1'b0;
      for (int k = 0; k < MAX_WRONG; k++)
        hist_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      rev_q    <= rev_d;
      wrong_q  <= wrong_d;
      guess_q  <= guess_d;
      strobe_q <= guess_strobe;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      rep_q    <= rep_d;
      for (int k = 0; k < MAX_WRONG; k++)
        hist_q[k] <= hist_d[k];
    end
  end

  // a lost game uncovers the whole word on the display only
  always_comb begin
    display_flat = '0;
    for (int i = 0; i < WORD_LEN; i++)
      display_flat[i*LW +: LW] =
        (rev_q[i] || state_q == S_LOSE) ?
        word_q[i*LW +: LW] : DASH;
  end

  always_comb begin
    game_status = 2'd0;
    unique case (state_q)
      S_IDLE:  game_status = 2'd3;
      S_WIN:   game_status = 2'd2;
      S_LOSE:  game_status = 2'd1;
      default: game_status = 2'd0;
    endcase
  end

  assign revealed     = rev_q;
  assign wrong_count  = wrong_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign repeat_guess = rep_q;

endmodule

// File: tb/tb_hangman_engine.sv
// Directed bench for hangman_engine: 4-letter table run plus
// reset-mid-EVAL and a 6-letter / 6-miss instance.
module tb_hangman_engine;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ng;
  logic [23:0] w;
  logic [5:0]  g;
  logic        stb;
  logic [23:0] disp;
  logic [3:0]  rev;
  logic [2:0]  wc;
  logic        hit, miss, rep;
  logic [1:0]  st;

  logic        ng2;
  logic [35:0] w2;
  logic [5:0]  g2;
  logic        stb2;
  logic [35:0] disp2;
  logic [5:0]  rev2;
  logic [2:0]  wc2;
  logic        hit2, miss2, rep2;
  logic [1:0]  st2;

  always #5 clk = ~clk;

  hangman_engine dut (
    .clk(clk), .resetn(resetn),
    .new_game(ng), .word_flat(w),
    .guess(g), .guess_strobe(stb),
    .display_flat(disp), .revealed(rev),
    .wrong_count(wc), .hit(hit),
    .miss(miss), .repeat_guess(rep),
    .game_status(st)
  );

  hangman_engine #(
    .WORD_LEN(6), .MAX_WRONG(6)
  ) dut2 (
    .clk(clk), .resetn(resetn),
    .new_game(ng2), .word_flat(w2),
    .guess(g2), .guess_strobe(stb2),
    .display_flat(disp2), .revealed(rev2),
    .wrong_count(wc2), .hit(hit2),
    .miss(miss2), .repeat_guess(rep2),
    .game_status(st2)
  );

  typedef struct {
    logic        ng;
    logic [23:0] w;
    logic        stb;
    logic [5:0]  g;
    logic        eh, em, er;
    logic [1:0]  st;
    logic [3:0]  rv;
    logic [2:0]  wc;
    logic [23:0] dp;
  } vec_t;

  vec_t        tbl[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [1:0]  c_st;
  logic [3:0]  c_rv;
  logic [2:0]  c_wc;
  logic [23:0] c_dp;

  function automatic logic [23:0] mkw(
    logic [5:0] a, logic [5:0] b,
    logic [5:0] c, logic [5:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(string nm, logic [63:0] a,
                     logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic set_cur(logic [1:0] s, logic [3:0] r,
                         logic [2:0] c, logic [23:0] d);
    c_st = s; c_rv = r; c_wc = c; c_dp = d;
  endtask

  task automatic pv(logic n, logic [23:0] wd, logic s,
                    logic [5:0] gg, logic eh, logic em,
                    logic er);
    vec_t v;
    v.ng = n; v.w = wd; v.stb = s; v.g = gg;
    v.eh = eh; v.em = em; v.er = er;
    v.st = c_st; v.rv = c_rv; v.wc = c_wc; v.dp = c_dp;
    tbl.push_back(v);
  endtask

  task automatic guess_v(logic [5:0] gg, logic eh, logic em,
                         logic er, logic [1:0] s,
                         logic [3:0] r, logic [2:0] c,
                         logic [23:0] d);
    pv(0, '0, 1, gg, 0, 0, 0);
    set_cur(s, r, c, d);
    pv(0, '0, 0, gg, eh, em, er);
  endtask

  task automatic ng_v(logic [23:0] wd, logic s,
                      logic [5:0] gg);
    set_cur(2'd0, '0, '0, '0);
    pv(1, wd, s, gg, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic g2v(logic [5:0] gg, logic eh, logic em,
                     logic er, logic [5:0] r,
                     logic [2:0] c, logic [1:0] s);
    g2 = gg; stb2 = 1'b1;
    step();
    chk("w6 eval pulse", {hit2, miss2, rep2}, 3'b000);
    stb2 = 1'b0;
    step();
    chk($sformatf("w6 %0h pulses", gg),
        {hit2, miss2, rep2}, {eh, em, er});
    chk($sformatf("w6 %0h rev", gg), rev2, r);
    chk($sformatf("w6 %0h wc", gg), wc2, c);
    chk($sformatf("w6 %0h st", gg), st2, s);
  endtask

  localparam logic [23:0] STAY =
    {6'h22, 6'h0A, 6'h1D, 6'h1C};
  localparam logic [23:0] LEEF =
    {6'h0F, 6'h0E, 6'h0E, 6'h15};
  localparam logic [23:0] D1 = 24'h00001C;

  initial begin
    resetn = 1'b1;
    ng = 0; w = '0; g = '0; stb = 0;
    ng2 = 0; w2 = '0; g2 = '0; stb2 = 0;

    ng_v(STAY, 0, '0);
    pv(0, '0, 1, 6'h1C, 0, 0, 0);
    set_cur(2'd0, 4'b0001, 3'd0, D1);
    pv(0, '0, 1, 6'h1C, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      pv(0, '0, 1, 6'h1C, 0, 0, 0);
    pv(0, '0, 0, 6'h1C, 0, 0, 0);
    guess_v(6'h1C, 0, 0, 1, 0, 4'b0001, 0, D1);
    guess_v(6'h11, 0, 1, 0, 0, 4'b0001, 1, D1);
    guess_v(6'h12, 0, 1, 0, 0, 4'b0001, 2, D1);
    guess_v(6'h13, 0, 1, 0, 0, 4'b0001, 3, D1);
    guess_v(6'h11, 0, 0, 1, 0, 4'b0001, 3, D1);
    guess_v(6'h17, 0, 1, 0, 1, 4'b0001, 4, STAY);
    guess_v(6'h1A, 0, 0, 0, 1, 4'b0001, 4, STAY);
    ng_v(STAY, 0, '0);
    guess_v(6'h00, 0, 0, 1, 0, 4'b0000, 0, '0);
    ng_v(LEEF, 1, 6'h0E);
    pv(0, '0, 1, 6'h0E, 0, 0, 0);
    pv(0, '0, 0, 6'h0E, 0, 0, 0);
    guess_v(6'h0E, 1, 0, 0, 0, 4'b0110, 0,
            mkw(6'h00, 6'h0E, 6'h0E, 6'h00));
    guess_v(6'h0E, 0, 0, 1, 0, 4'b0110, 0,
            mkw(6'h00, 6'h0E, 6'h0E, 6'h00));
    guess_v(6'h15, 1, 0, 0, 0, 4'b0111, 0,
            mkw(6'h15, 6'h0E, 6'h0E, 6'h00));
    guess_v(6'h0F, 1, 0, 0, 2, 4'b1111, 0, LEEF);
    guess_v(6'h11, 0, 0, 0, 2, 4'b1111, 0, LEEF);
    guess_v(6'h0F, 0, 0, 0, 2, 4'b1111, 0, LEEF);

    step();
    step();
    chk("reset st", st, 2'd3);
    chk("reset disp", disp, 24'h0);
    chk("reset rev", rev, 4'h0);
    chk("reset wc", wc, 3'd0);
    chk("reset pulses", {hit, miss, rep}, 3'b000);
    resetn = 1'b0;

    foreach (tbl[i]) begin
      ng = tbl[i].ng; w = tbl[i].w;
      stb = tbl[i].stb; g = tbl[i].g;
      step();
      chk($sformatf("v%0d pulses", i), {hit, miss, rep},
          {tbl[i].eh, tbl[i].em, tbl[i].er});
      chk($sformatf("v%0d st", i), st, tbl[i].st);
      chk($sformatf("v%0d rev", i), rev, tbl[i].rv);
      chk($sformatf("v%0d wc", i), wc, tbl[i].wc);
      chk($sformatf("v%0d disp", i), disp, tbl[i].dp);
    end

    ng = 1; w = STAY; stb = 0;
    step();
    ng = 0; g = 6'h1C; stb = 1;
    step();
    resetn = 1'b1;
    #1;
    chk("midreset st", st, 2'd3);
    chk("midreset rev", rev, 4'h0);
    chk("midreset disp", disp, 24'h0);
    @(posedge clk);
    #1;
    chk("midreset pulses", {hit, miss, rep}, 3'b000);
    chk("midreset st2", st, 2'd3);
    resetn = 1'b0;
    step();
    step();
    chk("idle edge pulses", {hit, miss, rep}, 3'b000);
    chk("idle edge st", st, 2'd3);
    stb = 0;

    ng2 = 1;
    w2 = {6'h0A, 6'h0E, 6'h0D, 6'h0C, 6'h0B, 6'h0A};
    step();
    ng2 = 0;
    chk("w6 start st", st2, 2'd0);
    chk("w6 start disp", disp2, 36'h0);
    g2v(6'h01, 0, 1, 0, 6'b000000, 3'd1, 2'd0);
    g2v(6'h02, 0, 1, 0, 6'b000000, 3'd2, 2'd0);
    g2v(6'h03, 0, 1, 0, 6'b000000, 3'd3, 2'd0);
    g2v(6'h04, 0, 1, 0, 6'b000000, 3'd4, 2'd0);
    g2v(6'h05, 0, 1, 0, 6'b000000, 3'd5, 2'd0);
    g2v(6'h0A, 1, 0, 0, 6'b100001, 3'd5, 2'd0);
    g2v(6'h0B, 1, 0, 0, 6'b100011, 3'd5, 2'd0);
    g2v(6'h0C, 1, 0, 0, 6'b100111, 3'd5, 2'd0);
    g2v(6'h0D, 1, 0, 0, 6'b101111, 3'd5, 2'd0);
    g2v(6'h0E, 1, 0, 0, 6'b111111, 3'd5, 2'd2);
    chk("w6 win disp", disp2,
        {6'h0A, 6'h0E, 6'h0D, 6'h0C, 6'h0B, 6'h0A});
    g2v(6'h06, 0, 0, 0, 6'b111111, 3'd5, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hangman_engine.md
Name: hangman_engine

Overview:
Parametrised game engine for N-letter hangman words. It latches a word on new_game and accepts one guess per rising edge of guess_strobe. It tracks revealed positions, wrong guesses and repeated guesses, and drives the per-position display codes plus the win/lose status into the existing hex decoders. It replaces the fixed 4-letter, free-running-compare control unit, so one button press counts as exactly one guess.

Parameters:
WORD_LEN, 4, number of letter positions (1..8)
LW, 6, letter code width in bits
MAX_WRONG, 4, wrong guesses that end the game (1..7)
WCW, 3, width of wrong_count; 2**WCW > MAX_WRONG required
DASH, 6'h00, display code for an unrevealed position

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous reset, active-high
new_game  input  1  sync pulse; latch word_flat and start a game
word_flat  input  WORD_LEN*LW  word; position i = bits [i*LW +: LW]; sampled only on new_game
guess  input  LW  letter code, sampled on strobe edge
guess_strobe  input  1  debounced, synchronous guess button level
display_flat  output  WORD_LEN*LW  per-position code: letter if revealed, else DASH
revealed  output  WORD_LEN  revealed-position mask
wrong_count  output  WCW  wrong guesses so far
hit  output  1  1-cycle pulse: guess revealed one or more new positions
miss  output  1  1-cycle pulse: new wrong guess, counted
repeat_guess  output  1  1-cycle pulse: guess already used, or guess==DASH; no penalty
game_status  output  2  0 PLAY, 1 LOSE, 2 WIN, 3 IDLE

Behaviour:
- Reset (async, resetn=1): state IDLE; word register, revealed, wrong_count, miss history, and the strobe delay flop cleared; hit/miss/repeat_guess 0; display_flat all DASH; game_status 3.
- FSM states are IDLE, PLAY, EVAL, WIN, LOSE.
- new_game from any state except during reset:
  - next edge: word_q <= word_flat, revealed <= 0, wrong_count <= 0, history cleared, state PLAY.
  - Takes priority over a concurrent strobe edge; that strobe edge is discarded.
- Strobe edge detection: strobe_q registers guess_strobe each cycle. An edge is guess_strobe=1 and strobe_q=0. A held button produces one edge only.
- PLAY, on an edge: guess_q <= guess, state EVAL. Edges in IDLE/WIN/LOSE are ignored; strobe_q still updates.
- EVAL (exactly one cycle):
  - match[i] = (word_q[i]==guess_q).
  - repeat when guess_q==DASH, OR (match & revealed) != 0 with (match & ~revealed)==0, OR guess_q equals a stored miss. Result: repeat_guess pulse; no other change.
  - hit when (match & ~revealed) != 0. Result: revealed |= match (all duplicate positions at once); hit pulse.
  - otherwise miss: store guess_q in history slot wrong_count; wrong_count += 1; miss pulse.
  - Next state:
    - WIN if the updated revealed is all ones.
    - LOSE if the updated wrong_count == MAX_WRONG.
    - Else PLAY.
- Latency: edge sampled at posedge N, EVAL at N+1. Pulses, revealed, wrong_count and game_status are registered and valid after posedge N+1, lasting 1 cycle for pulses. The earliest next accepted edge is posedge N+2.
- WIN and LOSE are mutually exclusive by construction; both are terminal until new_game or reset.
- In LOSE, display_flat shows the full word (all positions forced revealed on the output); revealed still reports the guessed mask.
- wrong_count saturates at MAX_WRONG and never wraps.
- Reset asserted mid-EVAL: no pulse is emitted and all state is cleared immediately.
- Outputs hit/miss/repeat_guess are registered, never combinational from guess.

Test Plan:
- Reset, then new_game with word S,T,A,Y (1C,1D,0A,22) -> status 0, display all 00, revealed 0000, wrong_count 0.
- Strobe 1C held for 10 cycles -> exactly one hit pulse 2 cycles after the edge; revealed 0001; display pos0=1C. Second 1C strobe -> repeat_guess, wrong_count stays 0.
- Word L,E,E,F (15,0E,0E,0F), strobe 0E -> one hit; revealed 0110. Then 15 and 0F -> WIN: status 2; further strobes give no pulses.
- Strobes 11,12,13,11,17 on STAY -> miss×3, repeat_guess on the second 11, then miss -> wrong_count 4, status 1, display 1C,1D,0A,22.
- Guess 00 -> repeat_guess, no count change. new_game coincident with a strobe edge -> fresh game, edge dropped, no pulse.
- resetn pulsed the cycle after a strobe edge -> no pulse, status 3, outputs at reset values. Repeat the WIN test with WORD_LEN=6, MAX_WRONG=6.
